// File: rtl/ab_burst_pkg.sv
// Shared types and widths for the A/B burst generator.
package ab_burst_pkg;

  localparam int PHASE_W     = 8;
  localparam int BURST_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_ONLY = 2'd1,
    A_B    = 2'd2,
    GAP    = 2'd3
  } ab_state_e;

  // Counter load value for a phase lasting n cycles (n >= 1).
  function automatic logic [PHASE_W-1:0] phase_load(input int unsigned n);
    return PHASE_W'(n - 1);
  endfunction

endpackage

// File: rtl/ab_phase_cnt.sv
// Loadable down-counter with zero flag; times the A_ONLY, A_B and GAP phases.
module ab_phase_cnt
  import ab_burst_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               zero
);

  logic [PHASE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ab_burst_gen.sv
// A/B handshake burst generator feeding the A/B protocol checker.
// Optional abort input/aborted pulse enabled by defining AB_BURST_ABORT_EN.
module ab_burst_gen
  import ab_burst_pkg::*;
#(
  parameter int B_AFTER     = 4,
  parameter int BOTH_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
`ifdef AB_BURST_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic                   a_out,
  output logic                   b_out,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_CNT_W-1:0] burst_cnt,
  output ab_state_e              state_dbg
);

  if (B_AFTER < 1 || B_AFTER > 255) begin : g_bad_b_after
    $fatal(1, "ab_burst_gen: B_AFTER must be in 1..255");
  end
  if (BOTH_CYCLES < 1 || BOTH_CYCLES > 255) begin : g_bad_both
    $fatal(1, "ab_burst_gen: BOTH_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $fatal(1, "ab_burst_gen: GAP_CYCLES must be in 0..255");
  end

  localparam bit                 HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [PHASE_W-1:0] B_LOAD    = phase_load(B_AFTER);
  localparam logic [PHASE_W-1:0] BOTH_LOAD = phase_load(BOTH_CYCLES);
  localparam logic [PHASE_W-1:0] GAP_LOAD  = HAS_GAP ? phase_load(GAP_CYCLES) : '0;

  ab_state_e              state_q, state_d;
  logic                   a_q, a_d, b_q, b_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   cnt_load, cnt_zero, abort_req;
  logic [PHASE_W-1:0]     cnt_val;

`ifdef AB_BURST_ABORT_EN
  assign abort_req = abort;
  assign aborted   = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  ab_phase_cnt u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = A_ONLY;
          cnt_load = 1'b1;
          cnt_val  = B_LOAD;
        end
      end
      A_ONLY, A_B: begin
        // Abort wins over a phase ending in the same cycle: no done, no count.
        if (abort_req) begin
          aborted_d = 1'b1;
          state_d   = HAS_GAP ? GAP : IDLE;
          cnt_load  = HAS_GAP;
          cnt_val   = GAP_LOAD;
        end else if (cnt_zero && state_q == A_ONLY) begin
          state_d  = A_B;
          cnt_load = 1'b1;
          cnt_val  = BOTH_LOAD;
        end else if (cnt_zero) begin
          done_d      = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          state_d     = HAS_GAP ? GAP : IDLE;
          cnt_load    = HAS_GAP;
          cnt_val     = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state, so A stays high across A_ONLY->A_B.
    a_d = (state_d == A_ONLY) || (state_d == A_B);
    b_d = (state_d == A_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign burst_cnt = burst_cnt_q;
  assign state_dbg = state_q;

`ifndef AB_BURST_ABORT_EN
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_ab_burst_gen.sv
// Scoreboard bench for ab_burst_gen: default instance plus a 1/1/0 instance for wrap.
module tb_ab_burst_gen;
  import ab_burst_pkg::*;

  localparam int EXP_W = 34;  // {aborted, done, a_len[7:0], b_len[7:0], burst_cnt[15:0]}

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_w;
  logic        a_out, b_out, busy, done;
  logic [15:0] burst_cnt;
  ab_state_e   state_dbg;
  logic        a_out_w, b_out_w, busy_w, done_w;
  logic [15:0] burst_cnt_w;
  ab_state_e   state_dbg_w;
  logic        aborted_s;

  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      exp_w_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 0;
  bit   seen_win = 0;
  int   low_run  = 0;
  logic [7:0] a_len = '0;
  logic [7:0] b_len = '0;

`ifdef AB_BURST_ABORT_EN
  logic abort;
  logic aborted_w;
`endif

  ab_burst_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef AB_BURST_ABORT_EN
    .abort     (abort),
    .aborted   (aborted_s),
`endif
    .a_out     (a_out),
    .b_out     (b_out),
    .busy      (busy),
    .done      (done),
    .burst_cnt (burst_cnt),
    .state_dbg (state_dbg)
  );

  ab_burst_gen #(.B_AFTER(1), .BOTH_CYCLES(1), .GAP_CYCLES(0)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .start     (start_w),
`ifdef AB_BURST_ABORT_EN
    .abort     (1'b0),
    .aborted   (aborted_w),
`endif
    .a_out     (a_out_w),
    .b_out     (b_out_w),
    .busy      (busy_w),
    .done      (done_w),
    .burst_cnt (burst_cnt_w),
    .state_dbg (state_dbg_w)
  );

`ifndef AB_BURST_ABORT_EN
  assign aborted_s = 1'b0;
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input bit ab, input bit dn, input int al,
                                              input int bl, input int cnt);
    return {ab, dn, 8'(al), 8'(bl), 16'(cnt)};
  endfunction

  // Driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(k < 200), 64'd1);
  endtask

  // Monitor for the default instance: one scoreboard entry per A window
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_out) begin
        if (a_len == 0 && seen_win) check("a_low_gap_ge2", 64'(low_run >= 2), 64'd1);
        check("no_done_mid_burst", 64'({aborted_s, done}), 64'd0);
        a_len   = a_len + 8'd1;
        if (b_out) b_len = b_len + 8'd1;
        low_run = 0;
      end else begin
        check("b_only_with_a", 64'(b_out), 64'd0);
        if (a_len != 0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL burst_unexpected: got a_len=%0d b_len=%0d cnt=%0d, expected none",
                     a_len, b_len, burst_cnt);
          end else begin
            check("burst", 64'({aborted_s, done, a_len, b_len, burst_cnt}), 64'(exp_q.pop_front()));
          end
          a_len    = '0;
          b_len    = '0;
          seen_win = 1;
        end else begin
          check("no_stray_done", 64'({aborted_s, done}), 64'd0);
        end
        if (low_run < 1000) low_run++;
      end
    end
  end

  // Monitor for the wrap instance: one entry per done pulse
  always @(negedge clk) begin
    if (mon_en && done_w) begin
      if (exp_w_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wrap_done_unexpected: got cnt=0x%0h, expected no done", burst_cnt_w);
      end else begin
        check("wrap_cnt_at_done", 64'(burst_cnt_w), 64'(exp_w_q.pop_front()));
      end
    end
  end

  initial begin
    logic [8:0] av, bv, dv, yv;
    logic [6:0] aw, bw, dw;
    rst     = 1'b1;
    start   = 1'b0;
    start_w = 1'b0;
`ifdef AB_BURST_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_w_outputs", 64'({a_out_w, b_out_w, busy_w, done_w, burst_cnt_w}), 64'd0);
    check("rst_w_state", 64'(state_dbg_w), 64'(IDLE));
    rst    = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // Single burst with cycle-exact waveform
    exp_q.push_back(mk_exp(0, 1, 6, 2, 1));
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      av = {av[7:0], a_out};
      bv = {bv[7:0], b_out};
      dv = {dv[7:0], done};
      yv = {yv[7:0], busy};
      @(negedge clk);
    end
    check("single_a_wave", 64'(av), 64'(9'b111111000));
    check("single_b_wave", 64'(bv), 64'(9'b000011000));
    check("single_done_wave", 64'(dv), 64'(9'b000000100));
    check("single_busy_wave", 64'(yv), 64'(9'b111111110));
    wait_idle("single_idle");
    check("single_cnt", 64'(burst_cnt), 64'd1);

    // Start held 40 cycles: five back-to-back bursts
    for (int n = 2; n <= 6; n++) exp_q.push_back(mk_exp(0, 1, 6, 2, n));
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_idle("held_idle");
    check("held_cnt", 64'(burst_cnt), 64'd6);

    // Start pulses inside A_ONLY and A_B are dropped
    exp_q.push_back(mk_exp(0, 1, 6, 2, 7));
    pulse_start();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_idle("ignore_idle");
    repeat (12) @(negedge clk);
    check("ignore_cnt", 64'(burst_cnt), 64'd7);

`ifdef AB_BURST_ABORT_EN
    // Abort in the second A_B cycle
    exp_q.push_back(mk_exp(1, 0, 6, 2, 7));
    pulse_start();
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", 64'({a_out, b_out, aborted_s}), 64'(3'b001));
    wait_idle("abort_idle");
    check("abort_cnt", 64'(burst_cnt), 64'd7);
`endif

    // Reset on the third A-high cycle
    exp_q.push_back(mk_exp(0, 0, 3, 0, 0));
    pulse_start();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_a_b", 64'({a_out, b_out}), 64'd0);
    check("midrst_busy_done", 64'({busy, done}), 64'd0);
    check("midrst_cnt", 64'(burst_cnt), 64'd0);
    repeat (10) @(negedge clk);
    check("midrst_cnt_after", 64'(burst_cnt), 64'd0);

    // Wrap instance: counter preset to 0xFFFF, then two back-to-back bursts
    force dut_w.burst_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_w.burst_cnt_q;
    @(negedge clk);
    check("wrap_preload", 64'(burst_cnt_w), 64'hFFFF);
    exp_w_q.push_back(16'h0000);
    exp_w_q.push_back(16'h0001);
    start_w = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      aw = {aw[5:0], a_out_w};
      bw = {bw[5:0], b_out_w};
      dw = {dw[5:0], done_w};
      if (i == 3) start_w = 1'b0;
      @(negedge clk);
    end
    check("wrap_a_wave", 64'(aw), 64'(7'b1101100));
    check("wrap_b_wave", 64'(bw), 64'(7'b0100100));
    check("wrap_done_wave", 64'(dw), 64'(7'b0010010));
    check("wrap_cnt_final", 64'(burst_cnt_w), 64'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("wrap_scoreboard_drained", 64'(exp_w_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
